// File: rtl/ir_burst_emitter.sv
// ir_burst_emitter
// Drives the IR emitter LED with a gated burst of square-wave carrier,
// n_pulses carrier periods long, followed by a fixed blanking gap.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     one-cycle burst request (ignored while busy)
//   n_pulses  carrier periods per burst, latched when start is accepted
//   busy      high during the burst and its blanking gap
//   done      one-cycle pulse in the first idle cycle after the gap
//   ir_out    emitter drive, active high
module ir_burst_emitter #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int CARRIER_HZ = 38_000,
  parameter int GAP_CYCLES = 2400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] n_pulses,
  output logic       busy,
  output logic       done,
  output logic       ir_out
);

  localparam int HALF  = CLK_HZ / (2 * CARRIER_HZ);
  localparam int PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(HALF - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        n_reg, n_next;
  logic [PH_W-1:0]   ph_reg, ph_next;
  logic [8:0]        hc_reg, hc_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              ir_reg, ir_next;

  logic accept, ph_wrap, burst_end, gap_end;

  assign accept    = (state_reg == IDLE) && start && (n_pulses != 8'd0);
  assign ph_wrap   = (ph_reg == PH_LAST);
  // The burst ends when the 2n-th half-period completes; that one is low.
  assign burst_end = ph_wrap && ((hc_reg + 9'd1) == {n_reg, 1'b0});
  assign gap_end   = (gap_reg == GAP_LAST);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      ph_reg    <= '0;
      hc_reg    <= '0;
      gap_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ir_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      ph_reg    <= ph_next;
      hc_reg    <= hc_next;
      gap_reg   <= gap_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      ir_reg    <= ir_next;
    end
  end

  // Next state and counters
  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    ph_next    = ph_reg;
    hc_next    = hc_reg;
    gap_next   = gap_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BURST;
          n_next     = n_pulses;
          ph_next    = '0;
          hc_next    = '0;
        end
      end
      BURST: begin
        if (ph_wrap) begin
          ph_next = '0;
          hc_next = hc_reg + 9'd1;
          if (burst_end) begin
            state_next = GAP;
            hc_next    = '0;
            gap_next   = '0;
          end
        end else begin
          ph_next = ph_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_end) begin
          state_next = IDLE;
          gap_next   = '0;
        end else begin
          gap_next = gap_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the next cycle, registered above
  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = (state_reg == GAP) && (state_next == IDLE);
    ir_next   = 1'b0;
    if (state_next == BURST) begin
      // First burst cycle starts high; afterwards toggle on each half-period wrap.
      if (state_reg == IDLE) ir_next = 1'b1;
      else                   ir_next = ph_wrap ? ~ir_reg : ir_reg;
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign ir_out = ir_reg;

endmodule

// File: tb/tb_ir_burst_emitter.sv
// Testbench for ir_burst_emitter: directed bursts, expected responses queued
// by the stimulus and checked by an independent monitor on each done pulse.
module tb_ir_burst_emitter;

  localparam int HALF = 157;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] n_pulses;
  logic       busy, done, ir_out;

  ir_burst_emitter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n_pulses (n_pulses),
    .busy     (busy),
    .done     (done),
    .ir_out   (ir_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int busy_len;
    int high_len;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: measures each burst and compares against the queue on done.
  int   m_busy = 0, m_high = 0, m_rises = 0, m_run = 0, m_phase_bad = 0;
  logic m_prev_ir = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0; m_high = 0; m_rises = 0; m_run = 0; m_phase_bad = 0;
        m_prev_ir = 1'b0;
        exp_q.delete();
      end else begin
        if (busy) begin
          m_busy++;
          if (ir_out) m_high++;
          if (ir_out && !m_prev_ir) m_rises++;
          if (m_busy == 1) m_run = 1;
          else if (ir_out != m_prev_ir) begin
            if (m_run != HALF) m_phase_bad++;
            m_run = 1;
          end else m_run++;
          m_prev_ir = ir_out;
        end
        if (done) begin
          chk("done_with_busy", int'(busy), 0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_done: got done=1 expected no done (queue empty)");
          end else begin
            e = exp_q.pop_front();
            chk("rising_edges", m_rises, e.n);
            chk("busy_cycles", m_busy, e.busy_len);
            chk("high_cycles", m_high, e.high_len);
            chk("phase_len_errors", m_phase_bad, 0);
            $display("burst n=%0d busy=%0d high=%0d rises=%0d", e.n, m_busy, m_high, m_rises);
          end
          m_busy = 0; m_high = 0; m_rises = 0; m_run = 0; m_phase_bad = 0;
          m_prev_ir = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input int n, input int busy_len, input int high_len);
    exp_t e;
    e.n = n; e.busy_len = busy_len; e.high_len = high_len;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    n_pulses = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 12000 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done expected done within 12000 cycles", name);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_pulses = 8'd0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_ir", int'(ir_out), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single period
    push_exp(1, 2714, 157);
    issue(1);
    @(negedge clk);
    chk("first_cycle_ir", int'(ir_out), 1);
    chk("first_cycle_busy", int'(busy), 1);
    wait_done("single");

    // Ten periods
    push_exp(10, 5540, 1570);
    issue(10);
    wait_done("ten");

    // Zero length is ignored
    issue(0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("zero_len_busy", int'(busy), 0);
    end

    // Start held high during a burst is ignored
    push_exp(2, 3028, 314);
    issue(2);
    repeat (400) @(posedge clk);
    #1 start = 1'b1; n_pulses = 8'd5;
    repeat (20) @(posedge clk);
    #1 start = 1'b0;
    wait_done("held_start");
    repeat (5) @(negedge clk);
    chk("held_start_not_queued", int'(busy), 0);

    // Back-to-back: start in the done cycle
    push_exp(1, 2714, 157);
    issue(1);
    wait_done("b2b_first");
    push_exp(3, 3342, 471);
    start = 1'b1; n_pulses = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_ir", int'(ir_out), 1);
    wait_done("b2b_second");

    // n_pulses changed mid-burst
    push_exp(4, 3656, 628);
    issue(4);
    repeat (300) @(posedge clk);
    #1 n_pulses = 8'd200;
    wait_done("input_change");

    // Asynchronous reset mid-burst
    push_exp(5, 3970, 785);
    issue(5);
    repeat (50) @(posedge clk);
    #1;
    chk("pre_reset_ir", int'(ir_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ir", int'(ir_out), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_done", int'(done), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4000) @(negedge clk);
    chk("post_reset_idle", int'(busy), 0);
    push_exp(2, 3028, 314);
    issue(2);
    wait_done("post_reset");

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_burst_emitter.md
# ir_burst_emitter

Transmitter side of the proximity-sensing link. It drives the IR emitter LED with gated bursts of a square-wave carrier whose length is set per request. Each burst is followed by a fixed blanking gap, so the receiver pin read by the sensor path is only exercised by a clean, counted burst. It sits beside the proximity-sensor reader in the top level and is triggered by a one-cycle `start` request.

## Interface
- `CLK_HZ`, default 12_000_000: system clock frequency in Hz.
- `CARRIER_HZ`, default 38_000: IR carrier frequency in Hz.
- `GAP_CYCLES`, default 2400: blanking gap after each burst, in clocks (200 µs at 12 MHz). Must be ≥ 1.
- Derived `HALF = CLK_HZ / (2*CARRIER_HZ)`, integer truncation: 157 with defaults. Must be ≥ 1.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: burst request, sampled on `clk`.
- `n_pulses` in 8: number of carrier periods in the burst. Sampled only when `start` is accepted.
- `busy` out 1: high while a burst or its gap is in progress.
- `done` out 1: one-cycle pulse when the gap ends.
- `ir_out` out 1: emitter drive, active high.

## Operation
- FSM states are IDLE, BURST and GAP.
- IDLE
  - `busy=0`, `ir_out=0`.
  - If `start=1` and `n_pulses≠0`: latch `n_pulses`, clear the half-period and half-count counters, go to BURST.
  - If `start=1` and `n_pulses=0`: the request is ignored. Stay in IDLE, no `busy`, no `done`.
- BURST
  - `busy=1`.
  - `ir_out` is high on the first BURST cycle and toggles every HALF clocks.
  - A half-period counter runs 0..HALF-1. A half-count counter (9 bits) counts completed half-periods.
  - After 2·n half-periods have completed (last half-period low), clear the counters and go to GAP.
- GAP
  - `busy=1`, `ir_out=0`.
  - A gap counter runs 0..GAP_CYCLES-1, then the FSM goes to IDLE.
- `done` is registered. It is 1 for exactly the first IDLE cycle after GAP, and 0 otherwise.
- `start` is ignored while `busy=1`. It is not queued.
- A `start` presented in the `done` cycle is accepted (the FSM is already in IDLE).
- A change on `n_pulses` after acceptance has no effect on the burst in progress.
- Counter widths:
  - Half-period counter: ≥ clog2(HALF) bits.
  - Gap counter: ≥ clog2(GAP_CYCLES) bits.
  - No counter wraps within its range.

## Timing
- Reset (`rst_n=0`) takes effect immediately, without waiting for `clk`. Reset values:
  - `busy=0`, `done=0`, `ir_out=0`, state IDLE.
  - Latched count and all counters are 0.
- Reset mid-burst or mid-gap aborts the operation with no `done` pulse. After release, the block waits for a new `start`.
- If `start` is accepted at edge E, then from E+1:
  - `busy=1` and `ir_out=1`.
  - `ir_out` is high for HALF cycles, then low for HALF cycles, repeated n times.
  - BURST therefore lasts 2·n·HALF cycles.
  - GAP follows immediately and lasts GAP_CYCLES cycles.
- `busy` is high for exactly 2·n·HALF + GAP_CYCLES cycles.
- `done` is high in the next cycle, which is also the first cycle with `busy=0`.
- Carrier period is 2·HALF clocks (314 with defaults, ≈38.2 kHz) with a 50 % duty cycle.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Single period, defaults.** Stimulus: `n_pulses=1`, `start` pulsed for one cycle. Required response:
  - `ir_out` is 1 for 157 cycles, then 0.
  - `busy` is high for 2714 cycles.
  - `done` is a single pulse on cycle 2715 after the start edge.
- **Multi-period burst.** Stimulus: `n_pulses=10`. Required response:
  - Exactly 10 rising edges on `ir_out`, each high phase 157 cycles and each low phase 157 cycles.
  - Burst lasts 3140 cycles, `busy` is high for 5540 cycles, then one `done` pulse.
- **Zero length and held start.** Stimulus: `n_pulses=0` with `start=1`, then a second `start` asserted while `busy=1` during an `n_pulses=2` burst. Required response:
  - The `n_pulses=0` request produces no `busy` and no `done`.
  - The second `start` is ignored: only one burst occurs, with exactly 2 rising edges.
- **Back-to-back.** Stimulus: `start` with `n_pulses=3` asserted in the `done` cycle. Required response: a new burst starts with `ir_out=1` on the next cycle, and there is no idle gap beyond GAP_CYCLES.
- **Input change mid-burst.** Stimulus: `n_pulses` changed from 4 to 200 mid-burst. Required response: the burst still contains exactly 4 carrier periods.
- **Asynchronous reset.** Stimulus: `rst_n` pulled low mid-burst while `ir_out=1`. Required response:
  - `ir_out`, `busy` and `done` go to 0 before the next `clk` edge.
  - No `done` pulse after release.
  - A fresh `start` produces a normal burst.
